// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, timing helpers and parity for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        REQ,
        SHIFT,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam int TIMER_W = 20;
    localparam int WDOG_W  = 20;

    localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

    // Widened to 64 bits so CLK_HZ * microseconds cannot overflow.
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        longint unsigned prod;
        prod = 64'(clk_hz) * 64'(us);
        return 32'(prod / 64'd1000000);
    endfunction

    localparam int unsigned DEFAULT_INHIBIT_CYC = us_to_cycles(DEFAULT_CLK_HZ, 100);
    localparam int unsigned DEFAULT_START_CYC   = us_to_cycles(DEFAULT_CLK_HZ, 5);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizer with falling-edge detect for one PS/2 line
module ps2_line_sync (
    input  logic clk,
    input  logic n_res,
    input  logic line,
    output logic level,
    output logic fall
);

    logic [2:0] sr;

    // Reset to the idle-high bus level so no edge is reported out of reset.
    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            sr <= 3'b111;
        end else begin
            sr <= {sr[1:0], line};
        end
    end

    assign level = sr[1];
    assign fall  = sr[2] & ~sr[1];

endmodule

// File: rtl/ps2_transmitter.sv
// rtl/ps2_transmitter.sv - PS/2 host-to-device byte transmitter with open-drain pull-low outputs
// Optional watchdog enabled by `define PS2_TX_TIMEOUT_EN.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned START_US   = 5,
    parameter int unsigned TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       n_res,
    input  logic       wr_stb,
    input  logic [7:0] wr_data,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       clk_low,
    output logic       dat_low,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(us_to_cycles(CLK_HZ, INHIBIT_US) - 32'd1);
    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(us_to_cycles(CLK_HZ, START_US) - 32'd1);
    localparam logic [WDOG_W-1:0]  WD_LAST    = WDOG_W'(us_to_cycles(CLK_HZ, TIMEOUT_MS * 32'd1000) - 32'd1);

    ps2_state_t         state;
    logic [8:0]         shreg;
    logic [3:0]         bit_cnt;
    logic [TIMER_W-1:0] timer;
    logic               clk_s, clk_fall, dat_s, dat_fall;
    logic               unused_ok;

    ps2_line_sync u_clk_sync (.clk(clk), .n_res(n_res), .line(ps2_clock), .level(clk_s), .fall(clk_fall));
    ps2_line_sync u_dat_sync (.clk(clk), .n_res(n_res), .line(ps2_data),  .level(dat_s), .fall(dat_fall));

    assign unused_ok  = &{1'b0, dat_fall, WD_LAST[0]};
    assign busy       = (state != IDLE);
    assign rx_inhibit = busy;

`ifdef PS2_TX_TIMEOUT_EN
    logic [WDOG_W-1:0] wd_cnt;
    logic              wd_expired;

    // Cleared throughout INHIBIT so counting begins at its exit; saturates once expired.
    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            wd_cnt <= '0;
        end else if (state == INHIBIT) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LAST) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_expired = (wd_cnt == WD_LAST) && (state inside {REQ, SHIFT, STOP, ACK, WAIT_IDLE});
`endif

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            timer   <= '0;
            clk_low <= 1'b0;
            dat_low <= 1'b0;
            done    <= 1'b0;
            ack_ok  <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A strobe coinciding with the done pulse belongs to the finished transfer.
                    if (wr_stb && !done) begin
                        shreg   <= {odd_parity(wr_data), wr_data};
                        ack_ok  <= 1'b0;
                        err     <= 1'b0;
                        timer   <= '0;
                        bit_cnt <= '0;
                        clk_low <= 1'b1;
                        state   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer == INH_LAST) begin
                        timer   <= '0;
                        dat_low <= 1'b1;
                        state   <= START;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                START: begin
                    if (timer == START_LAST) begin
                        timer   <= '0;
                        clk_low <= 1'b0;
                        bit_cnt <= '0;
                        state   <= REQ;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REQ, SHIFT: begin
                    if (clk_fall) begin
                        dat_low <= ~shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (state == REQ) begin
                            state <= SHIFT;
                        end else if (bit_cnt == 4'd8) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (clk_fall) begin
                        dat_low <= 1'b0;
                        bit_cnt <= bit_cnt + 4'd1;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (dat_s) begin
                            err <= 1'b1;
                        end else begin
                            ack_ok <= 1'b1;
                        end
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s && dat_s) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            if (wd_expired) begin
                clk_low <= 1'b0;
                dat_low <= 1'b0;
                ack_ok  <= 1'b0;
                err     <= 1'b1;
                done    <= 1'b1;
                state   <= IDLE;
            end
`endif
        end
    end

endmodule
